// File: rtl/dht11_frame_reader.sv
// rtl/dht11_frame_reader.sv - DHT11 single-wire frame reader (start pulse, preamble, 40-bit decode, checksum)
// Optional macro DHT11_GLITCH_FILTER_EN inserts a 3-sample agreement filter after the synchronizer.
module dht11_frame_reader #(
  parameter int CLKS_PER_US     = 25,
  parameter int START_LOW_US    = 18000,
  parameter int RELEASE_WAIT_US = 200,
  parameter int BIT_THRESH_US   = 40,
  parameter int TIMEOUT_US      = 150
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dht_in,
  output logic        dht_oe,
  output logic        busy,
  output logic        valid,
  output logic        checksum_ok,
  output logic        timeout_err,
  output logic [39:0] data
);

  localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  typedef enum logic [3:0] {
    IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, DONE, ERR
  } state_t;

  state_t state, next_state;

  logic [1:0]    sync_q;
  logic          line;
  logic          line_prev;
  logic          fall;
  logic          rise;
  logic [PW-1:0] presc;
  logic [15:0]   us_cnt;
  logic          us_tick;
  logic [5:0]    bit_cnt;
  logic [39:0]   shift;
  logic [39:0]   shift_next;
  logic          shift_en;
  logic          bit_val;
  logic [7:0]    sum8;

  // Line idles high through the pull-up, so the sampling chain resets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b11;
      line_prev <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], dht_in};
      line_prev <= line;
    end
  end

`ifdef DHT11_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist   <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist   <= {hist[0], sync_q[1]};
      filt_q <= line;
    end
  end

  // Level follows the line only once three consecutive samples agree.
  assign line = (sync_q[1] == hist[0] && hist[0] == hist[1]) ? sync_q[1] : filt_q;
`else
  assign line = sync_q[1];
`endif

  assign fall       = line_prev & ~line;
  assign rise       = ~line_prev & line;
  assign us_tick    = (presc == PW'(CLKS_PER_US - 1));
  assign bit_val    = (us_cnt > 16'(BIT_THRESH_US));
  assign shift_next = {shift[38:0], bit_val};
  assign sum8       = shift_next[39:32] + shift_next[31:24] + shift_next[23:16] + shift_next[15:8];

  always_comb begin
    next_state  = state;
    dht_oe      = 1'b0;
    busy        = 1'b1;
    valid       = 1'b0;
    timeout_err = 1'b0;
    shift_en    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = START_LOW;
      end
      START_LOW: begin
        dht_oe = 1'b1;
        if (us_cnt >= 16'(START_LOW_US)) next_state = RELEASE;
      end
      RELEASE: begin
        if (fall)                                  next_state = RESP_LOW;
        else if (us_cnt >= 16'(RELEASE_WAIT_US))   next_state = ERR;
      end
      RESP_LOW: begin
        if (rise)                                  next_state = RESP_HIGH;
        else if (us_cnt >= 16'(TIMEOUT_US))        next_state = ERR;
      end
      RESP_HIGH: begin
        if (fall)                                  next_state = BIT_LOW;
        else if (us_cnt >= 16'(TIMEOUT_US))        next_state = ERR;
      end
      BIT_LOW: begin
        if (rise)                                  next_state = BIT_HIGH;
        else if (us_cnt >= 16'(TIMEOUT_US))        next_state = ERR;
      end
      BIT_HIGH: begin
        if (fall) begin
          shift_en   = 1'b1;
          next_state = (bit_cnt == 6'd39) ? DONE : BIT_LOW;
        end else if (us_cnt >= 16'(TIMEOUT_US)) begin
          next_state = ERR;
        end
      end
      DONE: begin
        valid      = 1'b1;
        next_state = IDLE;
      end
      ERR: begin
        timeout_err = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Frame results are latched on the final falling edge so they are stable during the valid cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      presc       <= '0;
      us_cnt      <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      data        <= '0;
      checksum_ok <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        presc  <= '0;
        us_cnt <= '0;
      end else if (us_tick) begin
        presc  <= '0;
        us_cnt <= us_cnt + 16'd1;
      end else begin
        presc  <= presc + 1'b1;
      end

      if (state == IDLE && start) begin
        bit_cnt <= '0;
        shift   <= '0;
      end else if (shift_en) begin
        shift   <= shift_next;
        bit_cnt <= bit_cnt + 6'd1;
        if (bit_cnt == 6'd39) begin
          data        <= shift_next;
          checksum_ok <= (sum8 == shift_next[7:0]);
        end
      end
    end
  end

endmodule
